// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives the four input vectors 00, 01, 10, 11 onto an external
// 2-input gate and holds each one for SETTLE_CYCLES clocks. It then samples the gate
// output and compares it with a latched 4-bit truth table. At the end of a run it
// reports pass/fail, an error count and a per-vector failure bitmap.
//
// Optional feature: define GATE_CHK_STOP_ON_FAIL_EN to end the run at the first
// mismatching vector instead of always evaluating all four.
//
// Every output is a flop, so there is no combinational path from dut_y_i to any output.
module gate_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] truth_table_i,
    output logic       dut_a_o,
    output logic       dut_b_o,
    input  logic       dut_y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_count_o,
    output logic [3:0] fail_vec_o
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    // Last settle count value before moving to SAMPLE.
    localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] tt_q, tt_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    // Next-state logic: vector sequencing, settle counting and result accumulation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tt_d     = tt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        mismatch = (dut_y_i != tt_q[idx_q]);

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StDrive;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    tt_d    = truth_table_i;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (mismatch) begin
                    err_d  = err_q + 3'd1;
                    fail_d = fail_q | (4'b0001 << idx_q);
                end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                if (mismatch || (idx_q == 2'd3)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = StDrive;
                end
`else
                if (idx_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = StDrive;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // Status flags are computed from the next state so they can be registered.
        busy_d = (state_d == StDrive) || (state_d == StSample);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_d == 3'd0);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            tt_q    <= 4'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // The vector index is held in a register, so the gate inputs keep the last vector
    // while the checker is in IDLE, SAMPLE and DONE.
    assign dut_a_o     = idx_q[1];
    assign dut_b_o     = idx_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_vec_o  = fail_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (settle time 2 and settle time 1), each
// with a behavioural gate model on dut_y. A table of runs is applied. Expected results
// go into a scoreboard when start is driven and are popped when done rises. The state
// outputs are checked cycle by cycle against the documented cycle numbering.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic [3:0] tt;
    int         gsel;

    logic start0, start1;
    logic a0, b0, y0, busy0, done0, pass0;
    logic a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;

    logic cur_a, cur_b, cur_busy, cur_done, cur_pass;
    logic [2:0] cur_err;
    logic [3:0] cur_fail;

    int passed = 0;
    int total  = 0;

    // Gate codes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 output stuck at 1.
    function automatic logic gate_fn(input int g, input logic a, input logic b);
        case (g)
            0:       return a & b;
            1:       return ~(a & b);
            2:       return a | b;
            3:       return ~(a | b);
            4:       return a ^ b;
            5:       return ~(a ^ b);
            default: return 1'b1;
        endcase
    endfunction

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign y0 = gate_fn(gsel, a0, b0);
    assign y1 = gate_fn(gsel, a1, b1);

    assign cur_a    = sel ? a1 : a0;
    assign cur_b    = sel ? b1 : b0;
    assign cur_busy = sel ? busy1 : busy0;
    assign cur_done = sel ? done1 : done0;
    assign cur_pass = sel ? pass1 : pass0;
    assign cur_err  = sel ? err1 : err0;
    assign cur_fail = sel ? fail1 : fail0;

    gate_vector_checker #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .truth_table_i(tt),
        .dut_a_o(a0), .dut_b_o(b0), .dut_y_i(y0), .busy_o(busy0), .done_o(done0),
        .pass_o(pass0), .err_count_o(err0), .fail_vec_o(fail0)
    );

    gate_vector_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .truth_table_i(tt),
        .dut_a_o(a1), .dut_b_o(b1), .dut_y_i(y1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .err_count_o(err1), .fail_vec_o(fail1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         g;
        int         s;
        logic [3:0] tt;
        logic [2:0] err;
        logic [3:0] fail;
        int         glitch;
        int         ttchg;
    } vec_t;

    typedef struct {
        logic [2:0] err;
        logic [3:0] fail;
        logic       pass;
    } res_t;

    res_t sb[$];
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Start one run, then check the state outputs every cycle until done rises.
    task automatic run_check(input vec_t v);
        logic [2:0] eerr;
        logic [3:0] efail;
        int         lastk;
        int         done_c;
        int         k;
        bit         got;
        logic [4:0] exp_w;
        res_t       r;
        eerr  = v.err;
        efail = v.fail;
        lastk = 3;
        got   = 1'b0;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (v.fail != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (v.fail[i]) lastk = i;
            eerr  = 3'd1;
            efail = 4'b0001 << lastk;
        end
`endif
        sel    = (v.s == 1);
        gsel   = v.g;
        tt     = v.tt;
        done_c = (lastk + 1) * (v.s + 1) + 1;
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{eerr, efail, (eerr == 3'd0)});
        for (int c = 1; c <= done_c + 4 && !got; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == v.glitch) start = 1'b1;
            if (c == v.glitch + 1) start = 1'b0;
            if (c == v.ttchg) tt = ~v.tt;
            if (c < done_c) begin
                k = (c - 1) / (v.s + 1);
                exp_w = {3'b100, k[1:0]};
            end else begin
                exp_w = {2'b01, (eerr == 3'd0), lastk[1:0]};
            end
            check("busy_done_pass_ab", {cur_busy, cur_done, cur_pass, cur_a, cur_b}, exp_w);
            if (cur_done) begin
                r = sb.pop_front();
                check("err_count", cur_err, r.err);
                check("fail_vec", cur_fail, r.fail);
                got = 1'b1;
            end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            if (sb.size() > 0) r = sb.pop_front();
        end
        start = 1'b0;
    endtask

    initial begin
        // gate, S, truth table, err, fail, start-glitch cycle, table-change cycle
        tbl[0]  = '{1, 2, 4'b0111, 3'd0, 4'b0000, -1, -1};  // NAND pass
        tbl[1]  = '{0, 2, 4'b0111, 3'd4, 4'b1111, -1, -1};  // AND vs NAND table
        tbl[2]  = '{6, 2, 4'b0111, 3'd1, 4'b1000, -1, -1};  // NAND stuck at 1
        tbl[3]  = '{2, 2, 4'b1110, 3'd0, 4'b0000, -1, -1};  // OR
        tbl[4]  = '{4, 2, 4'b0110, 3'd0, 4'b0000, -1, -1};  // XOR
        tbl[5]  = '{3, 2, 4'b0001, 3'd0, 4'b0000, -1, -1};  // NOR
        tbl[6]  = '{5, 2, 4'b1001, 3'd0, 4'b0000, -1, -1};  // XNOR
        tbl[7]  = '{4, 2, 4'b0111, 3'd1, 4'b0001, -1, -1};  // XOR vs NAND table
        tbl[8]  = '{3, 2, 4'b0111, 3'd2, 4'b0110, -1, -1};  // NOR vs NAND table
        tbl[9]  = '{1, 2, 4'b0111, 3'd0, 4'b0000, 5, 2};    // start while busy, table change
        tbl[10] = '{1, 1, 4'b0111, 3'd0, 4'b0000, -1, -1};  // S=1 from IDLE
        tbl[11] = '{0, 1, 4'b0111, 3'd4, 4'b1111, -1, -1};  // S=1 restart from DONE

        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        gsel  = 1;
        tt    = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_s2", {a0, b0, busy0, done0, pass0, err0, fail0}, 0);
        check("reset_s1", {a1, b1, busy1, done1, pass1, err1, fail1}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_check(tbl[i]);

        // Reset in the middle of a run (SAMPLE of vector 1), then a clean run.
        sel  = 1'b0;
        gsel = 1;
        tt   = 4'b0111;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("pre_reset", {busy0, done0, a0, b0}, 4'b1001);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", {a0, b0, busy0, done0, pass0, err0, fail0}, 0);
        rst_n = 1'b1;
        run_check(tbl[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
